// File: rtl/myproject_mul_share_arbiter.sv
// myproject_mul_share_arbiter
//
// Purpose:
//   Time-shares one signed multiplier between NUM_REQ requesters. A round-robin arbiter
//   issues at most one operation per cycle into a fixed-latency, never-stalling pipeline.
//   Each result lands in a per-requester response slot that is held until it is accepted.
//   A requester may have only one operation in flight or held at a time.
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]             per-requester operation request
//   req_ready  out  [NUM_REQ]             one-hot grant, combinational
//   req_a      in   [NUM_REQ*DIN_WIDTH]   operand a, requester i at [i*DIN_WIDTH +: DIN_WIDTH]
//   req_b      in   [NUM_REQ*DIN_WIDTH]   operand b, same packing
//   rsp_valid  out  [NUM_REQ]             per-requester result available
//   rsp_ready  in   [NUM_REQ]             per-requester result accept
//   rsp_data   out  [NUM_REQ*DOUT_WIDTH]  per-requester result, [i*DOUT_WIDTH +: DOUT_WIDTH]
//   busy       out                        any operation in flight or any result held

module myproject_mul_share_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DIN_WIDTH   = 16,
   parameter int unsigned DOUT_WIDTH  = 30,
   parameter int unsigned MUL_LATENCY = 1
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DIN_WIDTH-1:0]    req_a,
   input  logic [NUM_REQ*DIN_WIDTH-1:0]    req_b,
   output logic [NUM_REQ-1:0]              rsp_valid,
   input  logic [NUM_REQ-1:0]              rsp_ready,
   output logic [NUM_REQ*DOUT_WIDTH-1:0]   rsp_data,
   output logic                            busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   // Arbitration state
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      w_ptr_nxt;
   logic [NUM_REQ-1:0]    r_outstanding;
   logic [NUM_REQ-1:0]    w_outstanding_nxt;
   logic [NUM_REQ-1:0]    w_elig;
   logic [NUM_REQ-1:0]    w_grant;
   logic [NUM_REQ-1:0]    w_accept;
   logic                  w_issue;
   logic [IDX_W-1:0]      w_tag;
   logic [DIN_WIDTH-1:0]  w_op_a;
   logic [DIN_WIDTH-1:0]  w_op_b;

   // Stage 0: registered operands feeding the multiplier
   logic                  r_s0_valid;
   logic [DIN_WIDTH-1:0]  r_s0_a;
   logic [DIN_WIDTH-1:0]  r_s0_b;
   logic [IDX_W-1:0]      r_s0_tag;
   logic [DOUT_WIDTH-1:0] w_prod;

   // Post-multiply register stages
   logic [MUL_LATENCY-1:0] r_pl_valid;
   logic [DOUT_WIDTH-1:0]  r_pl_data [MUL_LATENCY];
   logic [IDX_W-1:0]       r_pl_tag  [MUL_LATENCY];

   // Response slots
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [DOUT_WIDTH-1:0] r_rsp_data [NUM_REQ];
   logic                  w_wr;
   logic [IDX_W-1:0]      w_wr_tag;

   // Round-robin scan starting at the pointer. Grant is forced off while reset is asserted
   // so req_ready drops immediately, not just at the next edge.
   always_comb begin
      int unsigned      v_idx;
      logic [IDX_W-1:0] v_sel;
      w_elig  = req_valid & ~r_outstanding;
      w_grant = '0;
      w_issue = 1'b0;
      w_tag   = '0;
      v_idx   = 0;
      v_sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         v_idx = 32'(r_ptr) + k;
         if (v_idx >= NUM_REQ) begin
            v_idx = v_idx - NUM_REQ;
         end
         v_sel = IDX_W'(v_idx);
         if (!w_issue && w_elig[v_sel]) begin
            w_issue = 1'b1;
            w_tag   = v_sel;
         end
      end
      if (!ap_rst_n) begin
         w_issue = 1'b0;
      end
      if (w_issue) begin
         w_grant[w_tag] = 1'b1;
      end
   end

   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_issue) begin
         w_ptr_nxt = (w_tag == IDX_W'(NUM_REQ - 1)) ? '0 : w_tag + 1'b1;
      end
   end

   assign w_op_a   = req_a[w_tag*DIN_WIDTH +: DIN_WIDTH];
   assign w_op_b   = req_b[w_tag*DIN_WIDTH +: DIN_WIDTH];
   assign w_accept = r_rsp_valid & rsp_ready;

   // Issue and accept never hit the same requester on one edge: an accepted slot still
   // has its outstanding bit set, which blocks eligibility.
   assign w_outstanding_nxt = (r_outstanding & ~w_accept) | w_grant;

   // Product evaluated in DOUT_WIDTH context: the low DOUT_WIDTH bits of the full signed
   // product, so -32768*-32768 wraps to 0 at 30 bits.
   assign w_prod = DOUT_WIDTH'($signed(r_s0_a) * $signed(r_s0_b));

   assign w_wr     = r_pl_valid[MUL_LATENCY-1];
   assign w_wr_tag = r_pl_tag[MUL_LATENCY-1];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_ptr         <= '0;
         r_outstanding <= '0;
         r_s0_valid    <= 1'b0;
         r_s0_a        <= '0;
         r_s0_b        <= '0;
         r_s0_tag      <= '0;
         r_pl_valid    <= '0;
         for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            r_pl_data[i] <= '0;
            r_pl_tag[i]  <= '0;
         end
         r_rsp_valid   <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            r_rsp_data[i] <= '0;
         end
      end else begin
         r_ptr         <= w_ptr_nxt;
         r_outstanding <= w_outstanding_nxt;

         r_s0_valid <= w_issue;
         if (w_issue) begin
            r_s0_a   <= w_op_a;
            r_s0_b   <= w_op_b;
            r_s0_tag <= w_tag;
         end

         r_pl_valid[0] <= r_s0_valid;
         r_pl_data[0]  <= w_prod;
         r_pl_tag[0]   <= r_s0_tag;
         for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            r_pl_valid[i] <= r_pl_valid[i-1];
            r_pl_data[i]  <= r_pl_data[i-1];
            r_pl_tag[i]   <= r_pl_tag[i-1];
         end

         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
               r_rsp_valid[i] <= 1'b0;
            end
         end
         // Slot is free: its outstanding bit was set at issue and cannot clear before this
         if (w_wr) begin
            r_rsp_valid[w_wr_tag] <= 1'b1;
            r_rsp_data[w_wr_tag]  <= r_pl_data[MUL_LATENCY-1];
         end
      end
   end

   assign req_ready = w_grant;
   assign rsp_valid = r_rsp_valid;
   assign busy      = |r_outstanding;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign rsp_data[g*DOUT_WIDTH +: DOUT_WIDTH] = r_rsp_data[g];
   end

endmodule

// File: tb/tb_myproject_mul_share_arbiter.sv
// tb_myproject_mul_share_arbiter
//
// Purpose:
//   Directed self-checking bench for myproject_mul_share_arbiter with default parameters
//   (4 requesters, 16-bit operands, 30-bit truncated product, one post-multiply stage).
//   Inputs are driven 1 ns after the rising edge; outputs are sampled 1 ns later.

module tb_myproject_mul_share_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned OW = 30;

   logic              ap_clk;
   logic              ap_rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [NR*OW-1:0]  rsp_data;
   logic              busy;

   int n_total;
   int n_bad;

   myproject_mul_share_arbiter #(
      .NUM_REQ     (NR),
      .DIN_WIDTH   (DW),
      .DOUT_WIDTH  (OW),
      .MUL_LATENCY (1)
   ) u_dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] slot(input int unsigned i);
      return rsp_data[i*OW +: OW];
   endfunction

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_op(input int unsigned i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   task automatic do_reset();
      ap_rst_n  = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      step();
      step();
      ap_rst_n = 1'b1;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = '1;
      repeat (6) step();
      rsp_ready = '0;
   endtask

   // Single issue on requester i; result must appear exactly two edges after the issue edge.
   task automatic run_one(input string tag, input int unsigned i, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OW-1:0] exp);
      logic [NR-1:0] oh;
      oh = NR'(1) << i;
      set_op(i, a, b);
      req_valid = oh;
      rsp_ready = '0;
      #1;
      check_eq({tag, "_grant"}, 64'(req_ready), 64'(oh));
      step();
      req_valid = '0;
      #1;
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      check_eq({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
      step();
      check_eq({tag, "_lat2"}, 64'(rsp_valid), 64'd0);
      step();
      check_eq({tag, "_valid"}, 64'(rsp_valid), 64'(oh));
      check_eq({tag, "_data"}, 64'(slot(i)), 64'(exp));
      rsp_ready = oh;
      step();
      rsp_ready = '0;
      #1;
      check_eq({tag, "_clr"}, 64'(rsp_valid), 64'd0);
      check_eq({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int unsigned   r0_grants;
      logic          seen;
      n_total   = 0;
      n_bad     = 0;
      ap_rst_n  = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;

      // Reset values
      #2;
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      check_eq("rst_rspv", 64'(rsp_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_data", 64'(rsp_data), 64'd0);
      do_reset();

      // 1: basic op, 3 * -5 = -15
      run_one("t1", 0, 16'sd3, -16'sd5, 30'h3FFF_FFF1);

      // 2: all valid, all accepting -> 0,1,2,3,0,... ; results three cycles after grant
      do_reset();
      for (int unsigned i = 0; i < NR; i++) set_op(i, DW'(i + 1), 16'd10);
      req_valid = '1;
      rsp_ready = '1;
      for (int unsigned k = 0; k < 9; k++) begin
         #1;
         check_eq("rr_grant", 64'(req_ready), 64'(NR'(1) << (k % NR)));
         if (k >= 3) begin
            check_eq("rr_rspv", 64'(rsp_valid), 64'(NR'(1) << ((k - 3) % NR)));
            check_eq("rr_data", 64'(slot((k - 3) % NR)), 64'(((k - 3) % NR + 1) * 10));
         end
         step();
      end
      drain();
      #1;
      check_eq("rr_idle", 64'(busy), 64'd0);

      // 3: r2 result held for 10 cycles while r0 keeps being served
      do_reset();
      set_op(2, 16'sd7, -16'sd3);
      set_op(0, 16'sd2, 16'sd5);
      req_valid = 4'b0100;
      rsp_ready = 4'b0001;
      #1;
      check_eq("hold_g2", 64'(req_ready), 64'b0100);
      step();
      req_valid = 4'b0101;
      r0_grants = 0;
      for (int unsigned k = 1; k <= 10; k++) begin
         #1;
         if (req_ready[0]) r0_grants++;
         check_eq("hold_nog2", 64'(req_ready[2]), 64'd0);
         if (k >= 3) begin
            check_eq("hold_v2", 64'(rsp_valid[2]), 64'd1);
            check_eq("hold_d2", 64'(slot(2)), 64'(30'h3FFF_FFEB));
         end
         if (rsp_valid[0]) check_eq("hold_d0", 64'(slot(0)), 64'd10);
         step();
      end
      check_eq("hold_r0cnt", 64'(r0_grants), 64'd3);
      req_valid = '0;
      rsp_ready = 4'b0101;
      step();
      check_eq("hold_rel", 64'(rsp_valid[2]), 64'd0);
      drain();

      // 4: operand corners
      do_reset();
      run_one("t4a", 1, 16'h8000, 16'h8000, 30'h0000_0000);
      run_one("t4b", 1, 16'h7FFF, 16'h8000, 30'h0000_8000);
      run_one("t4c", 1, 16'h7FFF, 16'h7FFF, 30'h3FFF_0001);

      // 5: pointer at 1 with only r0 and r3 valid -> r3 then r0
      do_reset();
      run_one("t5pre", 0, 16'd1, 16'd1, 30'd1);
      set_op(3, 16'd4, 16'd4);
      req_valid = 4'b1001;
      #1;
      check_eq("ptr_first", 64'(req_ready), 64'b1000);
      step();
      check_eq("ptr_second", 64'(req_ready), 64'b0001);
      step();
      drain();

      // 6: asynchronous reset mid-flight
      do_reset();
      set_op(0, 16'd6, 16'd7);
      set_op(1, 16'd8, 16'd9);
      req_valid = 4'b0011;
      step();
      step();
      step();
      check_eq("arst_pre", 64'(rsp_valid[0]), 64'd1);
      #3;
      ap_rst_n = 1'b0;
      #1;
      check_eq("arst_ready", 64'(req_ready), 64'd0);
      check_eq("arst_rspv", 64'(rsp_valid), 64'd0);
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_data", 64'(rsp_data), 64'd0);
      req_valid = '0;
      @(posedge ap_clk);
      #3;
      ap_rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (rsp_valid != '0) seen = 1'b1;
      end
      check_eq("arst_stale", 64'(seen), 64'd0);
      req_valid = '1;
      #1;
      check_eq("arst_first", 64'(req_ready), 64'b0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
